// File: rtl/thumb_fetch_buffer.sv
// Thumb fetch front end: word reads from a 1-cycle instruction SRAM, split into halfwords, queued for decode.
// Latency 2 cycles fetch-to-decode (3 after redirect); fetch throttles so the in-flight word always fits.
module thumb_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IREQ,
    output logic [31:0] IADDR,
    output logic        IRW,
    input  logic [31:0] INSTR,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        HW_VALID,
    output logic [15:0] HW,
    output logic [31:0] HW_PC,
    input  logic        HW_READY
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 3);
    localparam logic [CW-1:0] FETCH_LIMIT = CW'(DEPTH - 2);

    typedef struct packed {
        logic [15:0] hw;
        logic [31:0] pc;
    } entry_t;

    logic [31:0]   fpc;
    logic [31:0]   req_addr;
    logic          inflight;
    logic          skip_lo;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] occupancy;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic [15:0]   last_hw;
    logic [31:0]   last_pc;
    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        entry0;
    entry_t        entry1;
    logic          push_en;
    logic [1:0]    n_push;
    logic          pop;
    logic          unused_pc_bit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign unused_pc_bit = REDIRECT_PC[0];

    // Reserve room for the word still on its way back before issuing another.
    assign occupancy = count + (inflight ? CW'(2) : CW'(0));
    assign IREQ      = !RESET && !REDIRECT && (occupancy <= FETCH_LIMIT);
    assign IADDR     = fpc;
    assign IRW       = 1'b0;

    assign head     = mem[rd_ptr];
    assign HW_VALID = (count != '0);
    assign HW       = HW_VALID ? head.hw : last_hw;
    assign HW_PC    = HW_VALID ? head.pc : last_pc;
    assign pop      = HW_VALID && HW_READY;

    assign push_en = inflight && !REDIRECT;

    always_comb begin
        n_push = 2'd0;
        entry0 = '{hw: INSTR[15:0],  pc: req_addr};
        entry1 = '{hw: INSTR[31:16], pc: req_addr + 32'd2};
        if (push_en) begin
            if (skip_lo) begin
                n_push = 2'd1;
                entry0 = entry1;
            end else begin
                n_push = 2'd2;
            end
        end
    end

    always_comb begin
        count_next  = count + CW'(n_push) - CW'(pop);
        wr_ptr_next = wr_ptr;
        if (n_push == 2'd1) begin
            wr_ptr_next = ptr_inc(wr_ptr);
        end else if (n_push == 2'd2) begin
            wr_ptr_next = ptr_inc(ptr_inc(wr_ptr));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fpc      <= {RESET_PC[31:2], 2'b00};
            req_addr <= '0;
            inflight <= 1'b0;
            skip_lo  <= RESET_PC[1];
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            last_hw  <= '0;
            last_pc  <= '0;
        end else begin
            if (pop) begin
                last_hw <= head.hw;
                last_pc <= head.pc;
                rd_ptr  <= ptr_inc(rd_ptr);
            end
            // Redirect overrides everything, including the pointer advance from a same-cycle pop.
            if (REDIRECT) begin
                fpc      <= {REDIRECT_PC[31:2], 2'b00};
                skip_lo  <= REDIRECT_PC[1];
                inflight <= 1'b0;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                inflight <= IREQ;
                if (IREQ) begin
                    fpc      <= fpc + 32'd4;
                    req_addr <= fpc;
                end
                if (push_en) begin
                    skip_lo <= 1'b0;
                end
                count  <= count_next;
                wr_ptr <= wr_ptr_next;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (n_push != 2'd0) begin
            mem[wr_ptr] <= entry0;
        end
        if (n_push == 2'd2) begin
            mem[ptr_inc(wr_ptr)] <= entry1;
        end
    end

    no_overflow: assert property (@(posedge CLK) disable iff (RESET) count_next <= CW'(DEPTH));

endmodule

// File: tb/tb_thumb_fetch_buffer.sv
// Bench for thumb_fetch_buffer: directed timing checks plus a randomized run scored against an ideal PC stream.
module tb_thumb_fetch_buffer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IREQ;
    logic [31:0] IADDR;
    logic        IRW;
    logic [31:0] INSTR = 32'h0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic        HW_VALID;
    logic [15:0] HW;
    logic [31:0] HW_PC;
    logic        HW_READY = 1'b0;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int n_req;

    thumb_fetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(6)) dut (
        .CLK(CLK), .RESET(RESET), .IREQ(IREQ), .IADDR(IADDR), .IRW(IRW), .INSTR(INSTR),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .HW_VALID(HW_VALID), .HW(HW),
        .HW_PC(HW_PC), .HW_READY(HW_READY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] memhalf(input logic [31:0] pc);
        case (pc)
            32'h0:   return 16'h4770;
            32'h2:   return 16'h2001;
            32'h4:   return 16'h3001;
            32'h6:   return 16'hE7FE;
            default: return (pc[16:1] * 16'h9E37) ^ pc[31:16] ^ 16'h1F3C;
        endcase
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {memhalf(a + 32'd2), memhalf(a)};
    endfunction

    // Instruction SRAM: data the cycle after the request, garbage otherwise.
    always @(posedge CLK) INSTR <= IREQ ? memword(IADDR) : 32'hDEAD_BEEF;

    typedef struct {
        logic [15:0] hw;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] tail_pc;

    function void top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{memhalf(tail_pc), tail_pc});
            tail_pc = tail_pc + 32'd2;
        end
    endfunction

    function void restart(input logic [31:0] pc);
        exp_q.delete();
        tail_pc = {pc[31:1], 1'b0};
        top_up();
    endfunction

    // Every halfword decode accepts must be the next one in program order from the last reset/redirect.
    always @(negedge CLK) begin
        if (RESET) begin
            restart(32'h0);
        end else begin
            if (HW_VALID && HW_READY) begin
                e = exp_q.pop_front();
                checks++;
                if (HW !== e.hw || HW_PC !== e.pc) begin
                    errors++;
                    $display("FAIL stream: got hw=%h pc=%h, expected hw=%h pc=%h", HW, HW_PC, e.hw, e.pc);
                end
                pops++;
                top_up();
            end
            if (REDIRECT) restart(REDIRECT_PC);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Inputs change 1ns after the edge; directed checks sample 3ns after the edge.
    task automatic drive_point();
        @(posedge CLK);
        #1;
    endtask

    task automatic sync_reset(input logic ready);
        drive_point();
        RESET = 1'b1;
        REDIRECT = 1'b0;
        HW_READY = ready;
        drive_point();
        RESET = 1'b0;
    endtask

    logic [15:0] t1_hw [4] = '{16'h4770, 16'h2001, 16'h3001, 16'hE7FE};

    initial begin
        HW_READY = 1'b1;
        repeat (3) drive_point();
        #2;
        chk("rst_ireq", IREQ, 0);
        chk("rst_irw", IRW, 0);
        chk("rst_valid", HW_VALID, 0);
        chk("rst_hw", HW, 0);
        chk("rst_hwpc", HW_PC, 0);
        chk("rst_iaddr", IADDR, 32'h0);

        // Reset fetch: back-to-back halfwords from cycle 2.
        drive_point();
        RESET = 1'b0;
        #2;
        chk("c0_ireq", IREQ, 1);
        chk("c0_iaddr", IADDR, 32'h0);
        drive_point(); #2;
        chk("c1_ireq", IREQ, 1);
        chk("c1_iaddr", IADDR, 32'h4);
        chk("c1_valid", HW_VALID, 0);
        for (int i = 0; i < 4; i++) begin
            drive_point(); #2;
            chk("t1_valid", HW_VALID, 1);
            chk("t1_hw", HW, t1_hw[i]);
            chk("t1_pc", HW_PC, 32'(2 * i));
        end

        // Backpressure from reset: three requests fill the six entries.
        sync_reset(1'b0);
        n_req = 0;
        repeat (10) begin
            #2;
            if (IREQ) n_req++;
            drive_point();
        end
        #2;
        chk("bp_nreq", n_req, 3);
        chk("bp_ireq", IREQ, 0);
        chk("bp_hw", HW, 16'h4770);
        chk("bp_pc", HW_PC, 32'h0);
        repeat (40) begin
            drive_point();
            HW_READY = ($urandom_range(0, 1) == 1);
        end

        // Odd-halfword redirect.
        drive_point();
        HW_READY = 1'b1;
        drive_point();
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0106;
        #2;
        chk("rd_n_ireq", IREQ, 0);
        drive_point();
        REDIRECT = 1'b0;
        #2;
        chk("rd_n1_ireq", IREQ, 1);
        chk("rd_n1_iaddr", IADDR, 32'h104);
        chk("rd_n1_valid", HW_VALID, 0);
        drive_point(); #2;
        chk("rd_n2_valid", HW_VALID, 0);
        drive_point(); #2;
        chk("rd_n3_valid", HW_VALID, 1);
        chk("rd_n3_hw", HW, memhalf(32'h106));
        chk("rd_n3_pc", HW_PC, 32'h106);
        drive_point(); #2;
        chk("rd_n4_hw", HW, memhalf(32'h108));
        chk("rd_n4_pc", HW_PC, 32'h108);

        // Redirect in the cycle the response for 0x8 returns.
        sync_reset(1'b1);
        drive_point();
        drive_point();
        drive_point();
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0200;
        #2;
        chk("col_ireq", IREQ, 0);
        drive_point();
        REDIRECT = 1'b0;
        #2;
        chk("col_n1_valid", HW_VALID, 0);
        drive_point(); #2;
        chk("col_n2_valid", HW_VALID, 0);
        drive_point(); #2;
        chk("col_n3_valid", HW_VALID, 1);
        chk("col_n3_pc", HW_PC, 32'h200);

        // Asynchronous reset between edges with four entries queued.
        sync_reset(1'b0);
        drive_point();
        drive_point();
        drive_point();
        #2;
        chk("ar_valid_before", HW_VALID, 1);
        #1;
        RESET = 1'b1;
        #1;
        chk("ar_valid", HW_VALID, 0);
        chk("ar_ireq", IREQ, 0);
        chk("ar_iaddr", IADDR, 32'h0);
        drive_point();
        RESET = 1'b0;
        HW_READY = 1'b1;
        #2;
        chk("ar_restart_ireq", IREQ, 1);
        chk("ar_restart_iaddr", IADDR, 32'h0);

        // Random backpressure and redirects, scored by the stream monitor.
        repeat (1500) begin
            drive_point();
            HW_READY = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 31) == 0) begin
                REDIRECT = 1'b1;
                REDIRECT_PC = $urandom();
            end else begin
                REDIRECT = 1'b0;
            end
        end
        drive_point();
        REDIRECT = 1'b0;
        HW_READY = 1'b1;
        repeat (20) drive_point();
        chk("rand_progress", (pops >= 500) ? 32'd1 : 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/thumb_fetch_buffer.md
# thumb_fetch_buffer

Instruction fetch front end for the ARM Thumb core, placed between the instruction SRAM and the decode stage. It issues word reads to the instruction memory (synchronous, one-cycle read latency). It splits each returned 32-bit word into two 16-bit Thumb halfwords and queues them in a small FIFO. It presents halfwords with their PCs to decode over a valid/ready handshake, and supports branch redirect with flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bit 0 ignored, bit 1 honoured.
- DEPTH, 6, halfword FIFO entries; must be even and ≥ 4.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IREQ  out  1  instruction memory read request.
- IADDR  out  32  word-aligned fetch address (bits [1:0] always 0).
- IRW  out  1  constant 0 (read only).
- INSTR  in  32  read data; valid the cycle after the IREQ cycle.
- REDIRECT  in  1  one-cycle pulse for a taken branch or exception.
- REDIRECT_PC  in  32  new PC, valid with REDIRECT; bit 0 ignored.
- HW_VALID  out  1  FIFO head is valid.
- HW  out  16  halfword at the FIFO head.
- HW_PC  out  32  byte address of HW.
- HW_READY  in  1  decode accepts the head this cycle.

## Operation
State:
- fpc: next word address to fetch.
- inflight: 1 bit, a request was issued last cycle.
- skip_lo: 1 bit, drop the low half of the next response.
- count: FIFO occupancy, 0..DEPTH.
- FIFO of {halfword, PC} entries.

Fetch request:
- IREQ = !RESET && !REDIRECT && (count + 2·inflight ≤ DEPTH−2).
- IADDR = fpc.
- On every IREQ edge: fpc += 4 and inflight ← 1. Otherwise inflight ← 0.

Response handling:
- When inflight=1 and REDIRECT=0, INSTR is written to the FIFO.
- Word layout is little-endian: INSTR[15:0] has PC = A, INSTR[31:16] has PC = A+2, where A is the address issued.
- If skip_lo=1, only INSTR[31:16] is pushed (one entry) and skip_lo clears. Otherwise both halves are pushed, low half first.

Consume:
- Pop occurs when HW_VALID && HW_READY.
- HW_VALID = (count ≠ 0).
- HW and HW_PC come from the head entry. When the FIFO is empty they hold their last values.

Count update:
- count_next = count + pushes (0/1/2) − pop (0/1), all in the same edge.
- The issue rule guarantees no overflow. Overflow is an assertion failure.

Redirect (REDIRECT=1 in cycle N):
- FIFO is flushed at the edge ending N (count ← 0). Any pop in cycle N still counts as accepted by decode.
- INSTR in cycle N is discarded. inflight ← 0. IREQ=0 in cycle N.
- fpc ← {REDIRECT_PC[31:2], 2'b00}. skip_lo ← REDIRECT_PC[1].
- Cycle N+1: IREQ=1, IADDR = aligned redirect address.
- Cycle N+2: response arrives. Cycle N+3: HW_VALID=1.

Reset:
- IREQ=0, IRW=0, HW_VALID=0, HW=0, HW_PC=0, count=0, inflight=0.
- fpc = {RESET_PC[31:2], 2'b00}, so IADDR shows this value during reset. skip_lo = RESET_PC[1].
- Asserting RESET mid-operation discards the FIFO and the in-flight response immediately.

## Timing
- Cycle 0 is the first cycle after RESET deasserts.
- Cycle 0: IREQ=1, IADDR=fpc.
- Cycle 1: INSTR valid and pushed.
- Cycle 2: HW_VALID=1. Fetch-to-decode latency is 2 cycles; after a redirect it is 3 cycles.
- With DEPTH=6 and HW_READY held high, throughput is one halfword per cycle with no bubbles from cycle 2 onward.
- HW_READY=0 holds the head entry stable. Fetch stops once count + 2·inflight > DEPTH−2.
- REDIRECT has priority over push, fetch and the FIFO contents. A pop in the same cycle is harmless.

## Test plan
- **Reset fetch:** RESET_PC=0; mem[0x0]=0x2001_4770, mem[0x4]=0xE7FE_3001; HW_READY=1 → IADDR 0x0 at cycle 0, 0x4 at cycle 1. Expected HW/HW_PC stream: 0x4770/0x0 at cycle 2, 0x2001/0x2 at cycle 3, 0x3001/0x4 at cycle 4, 0xE7FE/0x6 at cycle 5.
- **Backpressure:** HW_READY=0 from reset → exactly 3 IREQs issued, count reaches 6, IREQ stays 0. HW=0x4770 stays stable. Release HW_READY → in-order delivery with no loss or duplication.
- **Odd-halfword redirect:** REDIRECT, REDIRECT_PC=0x106 in cycle N → IREQ=0 in cycle N. IADDR=0x104 in cycle N+1. First output in cycle N+3 is mem[0x104][31:16] with HW_PC=0x106, followed by the low half of 0x108 with PC 0x108.
- **Redirect collides with response:** REDIRECT asserted the cycle INSTR returns for 0x8 → no halfword with PC 0x8 or 0xA ever appears. HW_VALID=0 in N+1 and N+2.
- **Simultaneous push and pop:** count=2, response arrives, HW_READY=1 → count=3 next cycle, head advances by exactly one.
- **Async reset mid-stream:** assert RESET between edges with count=4 → HW_VALID=0 and IREQ=0 immediately. After release, fetch restarts at RESET_PC.
